adder_tree_ctrl: RTL and testbench

//  Sequencer in front of adder_tree: accepts a 4-bit sample stream (valid/ready), packs up to
//  32 samples into a lane frame, fires one in_valid pulse into the tree, collects o_data, and

---
 rtl/adder_tree_ctrl.sv | 166 ++++++++++++++++
 tb/tb_adder_tree_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_ctrl.sv
// Sequencer in front of adder_tree: packs a 4-bit sample stream into lane frames, fires the tree,
// and accumulates NFRAME tree results per group. Optional WAIT timeout: ADT_CTRL_TIMEOUT_EN.
module adder_tree_ctrl #(
    parameter int unsigned NLANE   = 32,
    parameter int unsigned DW      = 4,
    parameter int unsigned SW      = 13,
    parameter int unsigned NFRAME  = 4,
    parameter int unsigned ACCW    = SW + $clog2(NFRAME),
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    input  logic [DW-1:0]               s_data,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic                        t_in_valid,
    output logic [NLANE*DW-1:0]         t_in_data,
    input  logic                        t_o_valid,
    input  logic [SW-1:0]               t_o_data,
    output logic                        m_valid,
    output logic [ACCW-1:0]             m_data,
    output logic [$clog2(NFRAME+1)-1:0] m_nfr,
    input  logic                        m_ready,
    output logic                        err
);

    localparam int unsigned IW = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam int unsigned FW = $clog2(NFRAME + 1);

    if (NFRAME < 1 || TIMEOUT < 1) begin : g_param_chk
        $error("adder_tree_ctrl: NFRAME and TIMEOUT must both be at least 1");
    end

    typedef enum logic [1:0] {
        ST_FILL,
        ST_FIRE,
        ST_WAIT,
        ST_OUT
    } state_e;

    state_e                     state_q, state_d;
    logic [NLANE-1:0][DW-1:0]   buf_q, buf_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [FW-1:0]              fcnt_q, fcnt_d;
    logic [ACCW-1:0]            acc_q, acc_d;
    logic                       last_q, last_d;
    logic                       done;
    logic [SW-1:0]              result;

`ifdef ADT_CTRL_TIMEOUT_EN
    localparam int unsigned WCW = $clog2(TIMEOUT + 1);
    logic [WCW-1:0]             wcnt_q, wcnt_d;
    logic                       err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        fcnt_d  = fcnt_q;
        acc_d   = acc_q;
        last_d  = last_q;
        done    = 1'b0;
        result  = '0;
`ifdef ADT_CTRL_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_FILL: begin
                if (s_valid) begin
                    buf_d[idx_q] = s_data;
                    idx_d        = idx_q + 1'b1;
                    if (idx_q == IW'(NLANE - 1) || s_last) begin
                        state_d = ST_FIRE;
                        last_d  = s_last;
                    end
                end
            end
            ST_FIRE: begin
                buf_d   = '0;
                idx_d   = '0;
                state_d = ST_WAIT;
`ifdef ADT_CTRL_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end
            ST_WAIT: begin
`ifdef ADT_CTRL_TIMEOUT_EN
                // A timed-out frame is booked as a zero result so the group still completes.
                if (t_o_valid) begin
                    done   = 1'b1;
                    result = t_o_data;
                end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
                    done   = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`else
                done   = t_o_valid;
                result = t_o_data;
`endif
                if (done) begin
                    acc_d  = acc_q + ACCW'(result);
                    fcnt_d = fcnt_q + 1'b1;
                    last_d = 1'b0;
                    if (fcnt_q == FW'(NFRAME - 1) || last_q)
                        state_d = ST_OUT;
                    else
                        state_d = ST_FILL;
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    acc_d   = '0;
                    fcnt_d  = '0;
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            buf_q   <= '0;
            idx_q   <= '0;
            fcnt_q  <= '0;
            acc_q   <= '0;
            last_q  <= 1'b0;
`ifdef ADT_CTRL_TIMEOUT_EN
            wcnt_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            acc_q   <= acc_d;
            last_q  <= last_d;
`ifdef ADT_CTRL_TIMEOUT_EN
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Outputs decode the registered state and are forced low for as long as rst is held.
    assign s_ready    = (state_q == ST_FILL) && !rst;
    assign t_in_valid = (state_q == ST_FIRE) && !rst;
    assign t_in_data  = t_in_valid ? buf_q : '0;
    assign m_valid    = (state_q == ST_OUT) && !rst;
    assign m_data     = m_valid ? acc_q : '0;
    assign m_nfr      = m_valid ? fcnt_q : '0;

`ifdef ADT_CTRL_TIMEOUT_EN
    assign err = err_q && !rst;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_tree_ctrl.sv
// Testbench for adder_tree_ctrl: emulates the adder tree with a fixed-latency lane summer and
// checks group sums against a frame/group model of the sample stream.
module tb_adder_tree_ctrl;

    localparam int NLANE  = 32;
    localparam int DW     = 4;
    localparam int SW     = 13;
    localparam int NFRAME = 4;
    localparam int ACCW   = 15;
    localparam int NFW    = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  s_valid = 1'b0;
    logic [DW-1:0]         s_data = '0;
    logic                  s_last = 1'b0;
    logic                  s_ready;
    logic                  t_in_valid;
    logic [NLANE*DW-1:0]   t_in_data;
    logic                  t_o_valid = 1'b0;
    logic [SW-1:0]         t_o_data = '0;
    logic                  m_valid;
    logic [ACCW-1:0]       m_data;
    logic [NFW-1:0]        m_nfr;
    logic                  m_ready = 1'b1;
    logic                  err;

    adder_tree_ctrl #(
        .NLANE(NLANE), .DW(DW), .SW(SW), .NFRAME(NFRAME), .ACCW(ACCW), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .t_in_valid(t_in_valid), .t_in_data(t_in_data),
        .t_o_valid(t_o_valid), .t_o_data(t_o_data),
        .m_valid(m_valid), .m_data(m_data), .m_nfr(m_nfr), .m_ready(m_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { int due; int sum; } tree_job_t;
    tree_job_t   tq[$];
    int          mq_data[$];
    int          mq_nfr[$];
    int          ncyc = 0;
    int          n_fire = 0;
    int          bad_zero = 0;
    int          tree_lat = 3;
    bit          tree_en = 1'b1;
    logic [NLANE*DW-1:0] last_frame = '0;

    logic [3:0]  smp_q[$];
    bit          lst_q[$];

    function automatic int lane_sum(input logic [NLANE*DW-1:0] v);
        int s = 0;
        for (int i = 0; i < NLANE; i++) s += int'(v[i*DW +: DW]);
        return s;
    endfunction

    // Tree emulation and output monitoring, sampled just after the falling edge.
    always begin
        @(negedge clk);
        #1;
        ncyc++;
        t_o_valid = 1'b0;
        t_o_data  = '0;
        if (tq.size() > 0 && tq[0].due <= ncyc) begin
            t_o_valid = 1'b1;
            t_o_data  = SW'(tq[0].sum);
            void'(tq.pop_front());
        end
        if (t_in_valid) begin
            n_fire++;
            last_frame = t_in_data;
            if (tree_en) tq.push_back('{due: ncyc + tree_lat, sum: lane_sum(t_in_data)});
        end else if (t_in_data != '0) begin
            bad_zero++;
        end
        if (m_valid && m_ready) begin
            mq_data.push_back(int'(m_data));
            mq_nfr.push_back(int'(m_nfr));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Group model: a frame closes after NLANE samples or on s_last; the list is one group.
    task automatic model(output int esum, output int enfr);
        int lane = 0;
        esum = 0;
        enfr = 0;
        for (int i = 0; i < smp_q.size(); i++) begin
            esum += int'(smp_q[i]);
            lane++;
            if (lane == NLANE || lst_q[i]) begin
                enfr++;
                lane = 0;
            end
        end
        if (lane != 0) enfr++;
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        int w;
        for (int i = lo; i < hi; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            s_valid = 1'b1;
            s_data  = smp_q[i];
            s_last  = lst_q[i];
            w = 0;
            while (!s_ready && w < 2000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 2000) begin
                chk("send_stall", 64'(s_ready), 64'd1);
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic check_group(input string tag);
        int esum, enfr, k;
        model(esum, enfr);
        k = 0;
        while (mq_data.size() == 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_arrived"}, 64'(mq_data.size() > 0), 64'd1);
        if (mq_data.size() > 0) begin
            chk({tag, "_data"}, 64'(mq_data.pop_front()), 64'(esum));
            chk({tag, "_nfr"}, 64'(mq_nfr.pop_front()), 64'(enfr));
        end
    endtask

    task automatic load(input int n, input int mode, input bit last_at_end);
        smp_q.delete();
        lst_q.delete();
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       smp_q.push_back(4'hF);
                1:       smp_q.push_back(4'h1);
                2:       smp_q.push_back(4'(i % 16));
                3:       smp_q.push_back(4'h7);
                default: smp_q.push_back(4'($urandom_range(0, 15)));
            endcase
            lst_q.push_back(last_at_end && (i == n - 1));
        end
    endtask

    initial begin
        logic [NLANE*DW-1:0] frm;
        logic [87:0]         hi;
        logic [39:0]         lo;
        int                  f0, d0, n0, nr;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_t_in_valid", 64'(t_in_valid), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("fill_s_ready", 64'(s_ready), 64'd1);

        // 4 full frames of 0xF
        load(128, 0, 1'b0);
        f0 = n_fire;
        send_range(0, 128, 1'b0);
        check_group("t1");
        chk("t1_fires", 64'(n_fire - f0), 64'd4);
        chk("t1_err", 64'(err), 64'd0);

        // short frame closed by s_last, latency and lane zero-fill
        load(10, 1, 1'b1);
        send_range(0, 10, 1'b0);
        chk("t2_fire_latency", 64'(t_in_valid), 64'd1);
        @(negedge clk);
        frm = last_frame;
        hi  = frm[127:40];
        lo  = frm[39:0];
        chk("t2_upper_lanes", 64'(hi), 64'd0);
        chk("t2_lower_lanes", 64'(lo), 64'h11_1111_1111);
        @(negedge clk);
        @(negedge clk);
        chk("t2_m_valid_early", 64'(m_valid), 64'd0);
        @(negedge clk);
        chk("t2_m_valid_on_time", 64'(m_valid), 64'd1);
        check_group("t2");

        // backpressure on the sum port
        m_ready = 1'b0;
        load(5, 4, 1'b1);
        send_range(0, 5, 1'b0);
        nr = 0;
        while (!m_valid && nr < 100) begin
            @(negedge clk);
            nr++;
        end
        d0 = int'(m_data);
        n0 = int'(m_nfr);
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", 64'(m_valid), 64'd1);
            chk("t3_hold_data", 64'(m_data), 64'(d0));
            chk("t3_hold_nfr", 64'(m_nfr), 64'(n0));
            chk("t3_s_ready", 64'(s_ready), 64'd0);
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("t3_released", 64'(m_valid), 64'd0);
        check_group("t3");

        // reset in WAIT; the tree result that arrives afterwards must be dropped
        load(32, 3, 1'b0);
        send_range(0, 32, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_rst_s_ready", 64'(s_ready), 64'd0);
        chk("t4_rst_m_valid", 64'(m_valid), 64'd0);
        chk("t4_rst_t_in_valid", 64'(t_in_valid), 64'd0);
        chk("t4_rst_m_data", 64'(m_data), 64'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t4_stale_ignored", 64'(m_valid), 64'd0);
        chk("t4_no_group", 64'(mq_data.size()), 64'd0);
        chk("t4_s_ready", 64'(s_ready), 64'd1);
        load(128, 1, 1'b0);
        send_range(0, 128, 1'b0);
        check_group("t4");

        // cyclic samples with random valid gaps
        load(128, 2, 1'b0);
        send_range(0, 128, 1'b1);
        check_group("t5");

        // frame of exactly NLANE samples with s_last on the final lane
        load(32, 4, 1'b1);
        send_range(0, 32, 1'b0);
        check_group("t5_full_last");

        // random lengths and data
        for (int r = 0; r < 4; r++) begin
            load($urandom_range(1, 128), 4, 1'b1);
            send_range(0, smp_q.size(), 1'b1);
            check_group("t5_rand");
        end

`ifdef ADT_CTRL_TIMEOUT_EN
        // tree never answers: each frame times out after 16 WAIT cycles
        tree_en = 1'b0;
        load(128, 0, 1'b0);
        send_range(0, 32, 1'b0);
        repeat (16) @(negedge clk);
        chk("t6_err_before", 64'(err), 64'd0);
        @(negedge clk);
        chk("t6_err_set", 64'(err), 64'd1);
        send_range(32, 128, 1'b0);
        begin
            int k;
            k = 0;
            while (mq_data.size() == 0 && k < 500) begin
                @(negedge clk);
                k++;
            end
            chk("t6_arrived", 64'(mq_data.size() > 0), 64'd1);
            if (mq_data.size() > 0) begin
                chk("t6_data", 64'(mq_data.pop_front()), 64'd0);
                chk("t6_nfr", 64'(mq_nfr.pop_front()), 64'd4);
            end
        end
        chk("t6_err_sticky", 64'(err), 64'd1);
        tree_en = 1'b1;
`else
        chk("end_err", 64'(err), 64'd0);
`endif

        chk("tin_zero_outside_fire", 64'(bad_zero), 64'd0);
        chk("no_extra_groups", 64'(mq_data.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
